gf_mixcol_pipe: RTL and testbench



---
 rtl/aes_gf_pkg.sv | 26 ++
 rtl/gf_mul_col.sv | 22 ++
 rtl/gf_mixcol_pipe.sv | 145 ++++++++++++++
 tb/tb_gf_mixcol_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) types and helpers for the AES column-mix datapath.
// Latency: n/a (package only).
// Backpressure: n/a.
package aes_gf_pkg;

  localparam logic [7:0] AES_POLY    = 8'h1B;
  localparam logic       MODE_MIX    = 1'b0;
  localparam logic       MODE_INVMIX = 1'b1;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] col_t;

  // a, b2, b4, b8 for the four bytes of one column; row 0 sits in the top byte of each field.
  typedef struct packed {
    col_t a;
    col_t b2;
    col_t b4;
    col_t b8;
  } col_prod_t;

  // Multiply by x modulo the AES polynomial.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/gf_mul_col.sv
// Per-column doubling chain: produces a, 2a, 4a, 8a for every byte of one column.
// Latency: purely combinational.
// Backpressure: none; the caller owns all flow control.
// Ports: col_i = input column, prod_o = {a, b2, b4, b8} (128 bits).
module gf_mul_col
  import aes_gf_pkg::*;
(
  input  col_t      col_i,
  output col_prod_t prod_o
);

  always_comb begin
    prod_o   = '0;
    prod_o.a = col_i;
    for (int r = 0; r < 4; r++) begin
      prod_o.b2[31-8*r -: 8] = xtime(col_i[31-8*r -: 8]);
      prod_o.b4[31-8*r -: 8] = xtime(xtime(col_i[31-8*r -: 8]));
      prod_o.b8[31-8*r -: 8] = xtime(xtime(xtime(col_i[31-8*r -: 8])));
    end
  end

endmodule

// File: rtl/gf_mixcol_pipe.sv
// Pipelined AES MixColumns / InvMixColumns over NCOL columns per beat, mode chosen per beat.
// Latency: PIPE_STAGES cycles from input transfer to out_valid; 1 beat/cycle when unstalled.
// Backpressure: valid/ready; empty stages always accept, in_ready depends only on stage state and out_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_mode/in_data upstream;
//        out_valid/out_ready/out_mode/out_data downstream; busy = any stage holding a beat.
module gf_mixcol_pipe
  import aes_gf_pkg::*;
#(
  parameter int NCOL        = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [32*NCOL-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mode,
  output logic [32*NCOL-1:0] out_data,
  output logic              busy
);

  if (NCOL < 1 || NCOL > 4) begin : g_bad_ncol
    $error("gf_mixcol_pipe: NCOL must be 1..4");
  end
  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_pipe
    $error("gf_mixcol_pipe: PIPE_STAGES must be 1 or 2");
  end

  function automatic byte_t pb(input col_t c, input int row);
    return c[31-8*row -: 8];
  endfunction

  // Mode-selected XOR network over the precomputed multiples of one column.
  function automatic col_t mix_col(input logic mode, input col_prod_t p);
    col_t  r;
    byte_t ri;
    int    i1, i2, i3;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      i1 = (i + 1) % 4;
      i2 = (i + 2) % 4;
      i3 = (i + 3) % 4;
      if (mode == MODE_INVMIX) begin
        ri = (pb(p.b8, i)  ^ pb(p.b4, i)  ^ pb(p.b2, i))    // x14
           ^ (pb(p.b8, i1) ^ pb(p.b2, i1) ^ pb(p.a, i1))    // x11
           ^ (pb(p.b8, i2) ^ pb(p.b4, i2) ^ pb(p.a, i2))    // x13
           ^ (pb(p.b8, i3) ^ pb(p.a, i3));                  // x9
      end else begin
        ri = pb(p.b2, i) ^ (pb(p.b2, i1) ^ pb(p.a, i1)) ^ pb(p.a, i2) ^ pb(p.a, i3);
      end
      r[31-8*i -: 8] = ri;
    end
    return r;
  endfunction

  col_prod_t [NCOL-1:0] prod_in;

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    gf_mul_col u_mul (
      .col_i  (in_data[32*c +: 32]),
      .prod_o (prod_in[c])
    );
  end

  if (PIPE_STAGES == 1) begin : g_one
    logic               vld_q, mode_q, adv;
    logic [32*NCOL-1:0] dat_q, dat_d;

    assign adv = !vld_q || out_ready;

    always_comb begin
      dat_d = '0;
      for (int c = 0; c < NCOL; c++) dat_d[32*c +: 32] = mix_col(in_mode, prod_in[c]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        mode_q <= 1'b0;
        dat_q  <= '0;
      end else if (adv) begin
        vld_q <= in_valid;
        if (in_valid) begin
          mode_q <= in_mode;
          dat_q  <= dat_d;
        end
      end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q;
    assign out_mode  = mode_q;
    assign out_data  = dat_q;
    assign busy      = vld_q;
  end else begin : g_two
    logic                 s1_vld_q, s1_mode_q, s2_vld_q, s2_mode_q;
    logic                 adv1, adv2;
    col_prod_t [NCOL-1:0] s1_prod_q;
    logic [32*NCOL-1:0]   s2_dat_q, s2_dat_d;

    assign adv2 = !s2_vld_q || out_ready;
    assign adv1 = !s1_vld_q || adv2;

    always_comb begin
      s2_dat_d = '0;
      for (int c = 0; c < NCOL; c++) s2_dat_d[32*c +: 32] = mix_col(s1_mode_q, s1_prod_q[c]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_vld_q  <= 1'b0;
        s1_mode_q <= 1'b0;
        s1_prod_q <= '0;
        s2_vld_q  <= 1'b0;
        s2_mode_q <= 1'b0;
        s2_dat_q  <= '0;
      end else begin
        if (adv1) begin
          s1_vld_q <= in_valid;
          if (in_valid) begin
            s1_mode_q <= in_mode;
            s1_prod_q <= prod_in;
          end
        end
        if (adv2) begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) begin
            s2_mode_q <= s1_mode_q;
            s2_dat_q  <= s2_dat_d;
          end
        end
      end
    end

    assign in_ready  = adv1;
    assign out_valid = s2_vld_q;
    assign out_mode  = s2_mode_q;
    assign out_data  = s2_dat_q;
    assign busy      = s1_vld_q | s2_vld_q;
  end

endmodule

// File: tb/tb_gf_mixcol_pipe.sv
// Self-checking bench: directed AES vectors, streaming, backpressure, reset and random stalls
// against a GF(2^8) matrix-multiply reference, for NCOL=4/2-stage and NCOL=1/1-stage builds.
// Inputs driven 1 time unit after posedge, everything observed on negedge.
module tb_gf_mixcol_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_mode, out_ready, phase;
  logic [127:0] in_data;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_mode, a_busy;
  logic [127:0] a_out_data;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_mode, b_busy;
  logic [31:0]  b_out_data;

  assign a_in_valid = in_valid & ~phase;
  assign b_in_valid = in_valid & phase;

  gf_mixcol_pipe #(.NCOL(4), .PIPE_STAGES(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_mode(a_out_mode),
    .out_data(a_out_data), .busy(a_busy)
  );

  gf_mixcol_pipe #(.NCOL(1), .PIPE_STAGES(1)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(in_mode),
    .in_data(in_data[31:0]), .out_valid(b_out_valid), .out_ready(out_ready), .out_mode(b_out_mode),
    .out_data(b_out_data), .busy(b_busy)
  );

  logic         mon_in_ready, mon_out_valid, mon_out_mode, mon_busy;
  logic [127:0] mon_out_data;
  assign mon_in_ready  = phase ? b_in_ready  : a_in_ready;
  assign mon_out_valid = phase ? b_out_valid : a_out_valid;
  assign mon_out_mode  = phase ? b_out_mode  : a_out_mode;
  assign mon_busy      = phase ? b_busy      : a_busy;
  assign mon_out_data  = phase ? {96'b0, b_out_data} : a_out_data;

  int n_vec = 0, n_bad = 0, n_out = 0, cyc = 0;
  int lat = 2, ncol = 4;
  bit stall_on = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- reference model: plain GF(2^8) multiply and the AES circulant matrices ----
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p ^= x;
      hi = x[7];
      x  = x << 1;
      if (hi) x ^= 8'h1b;
      y  = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_col(input logic m, input logic [31:0] a);
    logic [7:0]  cf[4];
    logic [7:0]  ri;
    logic [31:0] r;
    if (m) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else   cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int i = 0; i < 4; i++) begin
      ri = 8'h00;
      for (int j = 0; j < 4; j++) ri ^= gmul(cf[(j - i + 4) % 4], a[31-8*j -: 8]);
      r[31-8*i -: 8] = ri;
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_beat(input logic m, input logic [127:0] d, input int nc);
    logic [127:0] r = '0;
    for (int c = 0; c < nc; c++) r[32*c +: 32] = ref_col(m, d[32*c +: 32]);
    return r;
  endfunction

  function automatic logic [127:0] rep(input logic [31:0] c);
    return phase ? {96'b0, c} : {4{c}};
  endfunction

  typedef struct { logic m; logic [127:0] d; } exp_t;
  exp_t         q[$];
  logic         stall_prev = 1'b0, prev_mode;
  logic [127:0] prev_dat;

  // Scoreboard: inputs recorded when accepted, outputs compared in order.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 128'(mon_out_valid), 128'(1));
        chk("hold_data", mon_out_data, prev_dat);
        chk("hold_mode", 128'(mon_out_mode), 128'(prev_mode));
      end
      if (mon_out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) chk("spurious_out", 128'(1), 128'(0));
        else begin
          e = q.pop_front();
          chk("out_data", mon_out_data, e.d);
          chk("out_mode", 128'(mon_out_mode), 128'(e.m));
        end
      end
      if (in_valid && mon_in_ready) begin
        e.m = in_mode;
        e.d = ref_beat(in_mode, in_data, ncol);
        q.push_back(e);
      end
      stall_prev = mon_out_valid && !out_ready;
      prev_dat   = mon_out_data;
      prev_mode  = mon_out_mode;
    end
  end

  task automatic send(input logic m, input logic [127:0] d);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (mon_in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 128'(0), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || mon_busy) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_timeout", 128'(q.size()), 128'(0));
  endtask

  task automatic known(input logic m, input logic [31:0] ci, input logic [31:0] co);
    send(m, rep(ci));
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("latency_valid", 128'(mon_out_valid), 128'(k == lat));
    end
    chk("known_data", mon_out_data, rep(co));
    chk("known_mode", 128'(mon_out_mode), 128'(m));
    @(posedge clk);
    #1;
  endtask

  task automatic run_suite();
    int c0, n0;
    out_ready = 1'b1;
    known(1'b0, 32'hdb135345, 32'h8e4da1bc);
    known(1'b1, 32'h8e4da1bc, 32'hdb135345);
    known(1'b1, 32'h01000000, 32'h0e090d0b);
    known(1'b0, 32'h01000000, 32'h02010103);
    known(1'b0, 32'hc6c6c6c6, 32'hc6c6c6c6);
    known(1'b1, 32'hc6c6c6c6, 32'hc6c6c6c6);
    known(1'b0, 32'h01010101, 32'h01010101);
    known(1'b1, 32'h01010101, 32'h01010101);
    known(1'b0, 32'hf20a225c, 32'h9fdc589d);
    known(1'b1, 32'h9fdc589d, 32'hf20a225c);

    // back-to-back alternating modes
    c0 = cyc;
    n0 = n_out;
    for (int i = 0; i < 16; i++) send(i[0], rep(i[0] ? 32'h9fdc589d : 32'hf20a225c));
    chk("stream_cycles", 128'(cyc - c0), 128'(16));
    drain();
    chk("stream_count", 128'(n_out - n0), 128'(16));

    // backpressure with a full pipe plus one beat waiting
    n0 = n_out;
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, {$urandom, $urandom, $urandom, $urandom});
        send(1'b1, {$urandom, $urandom, $urandom, $urandom});
        send(1'b0, {$urandom, $urandom, $urandom, $urandom});
      end
    join_none
    repeat (lat) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(mon_in_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait fork;
    drain();
    chk("bp_count", 128'(n_out - n0), 128'(3));

    // random traffic with random output stalls
    stall_on = 1'b1;
    fork
      begin
        while (stall_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
    end
    stall_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // reset with beats in flight and a beat offered during reset
    send(1'b0, {$urandom, $urandom, $urandom, $urandom});
    send(1'b1, {$urandom, $urandom, $urandom, $urandom});
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 128'(mon_out_valid), 128'(0));
    chk("post_rst_busy", 128'(mon_busy), 128'(0));
    chk("post_rst_in_ready", 128'(mon_in_ready), 128'(1));
    n0 = n_out;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_beat", 128'(mon_out_valid), 128'(0));
    end
    chk("post_rst_count", 128'(n_out - n0), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    phase     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(a_out_valid), 128'(0));
    chk("rst_busy", 128'(a_busy), 128'(0));
    chk("rst_out_data", a_out_data, 128'(0));
    chk("rst_out_mode", 128'(a_out_mode), 128'(0));
    chk("rst_b_out_valid", 128'(b_out_valid), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(a_in_ready), 128'(1));
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      phase = p[0];
      lat   = p ? 1 : 2;
      ncol  = p ? 1 : 4;
      run_suite();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
